// File: rtl/running_max_tracker.sv
// Windowed running-maximum tracker: accepts WINDOW samples over valid/ready,
// then presents the window maximum and its 0-based position until consumed.
module running_max_tracker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WINDOW = 8,
    parameter int unsigned IDX_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx
);

    typedef enum logic [0:0] {StAccum, StEmit} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_xfer;
    logic             out_xfer;
    logic             take;

    // Two-bit-pair magnitude compare: low pair only matters when high pairs tie.
    function automatic logic gt4(input logic [3:0] a, input logic [3:0] b);
        logic gt_hi, eq_hi, gt_lo;
        gt_hi = (a[3:2] > b[3:2]);
        eq_hi = (a[3:2] == b[3:2]);
        gt_lo = (a[1:0] > b[1:0]);
        return gt_hi | (eq_hi & gt_lo);
    endfunction

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_d     = max_q;
        idx_d     = idx_q;
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StEmit);
        in_xfer   = in_valid & in_ready & ~clear;
        out_xfer  = out_valid & out_ready;
        take      = 1'b0;

        if (clear) begin
            state_d = StAccum;
            count_d = '0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (in_xfer) begin
                        // First sample of a window loads unconditionally; ties keep the old index.
                        take = (count_q == '0) || gt4(in_data, max_q);
                        if (take) begin
                            max_d = in_data;
                            idx_d = count_q;
                        end
                        if (count_q == LastIdx) begin
                            count_d = '0;
                            state_d = StEmit;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (out_xfer) state_d = StAccum;
                end
                default: state_d = StAccum;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            count_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

    // Running max is frozen while in EMIT, so it doubles as the result register.
    assign out_max = max_q;
    assign out_idx = idx_q;

endmodule

// File: tb/tb_running_max_tracker.sv
// Directed bench for running_max_tracker: WINDOW=8 instance plus a WINDOW=1 instance,
// with a queue of expected results compared as each result appears.
module tb_running_max_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_data, out_max;
    logic [2:0] out_idx;

    logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
    logic [3:0] w1_in_data, w1_out_max;
    logic [0:0] w1_out_idx;

    int checks = 0;
    int errors = 0;

    typedef logic [3:0] win_t [8];
    logic [6:0] exp_q [$];
    logic [6:0] last_exp;

    always #5 clk = ~clk;

    running_max_tracker #(.WIDTH(4), .WINDOW(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
        .out_idx(out_idx)
    );

    running_max_tracker #(.WIDTH(4), .WINDOW(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(w1_in_valid),
        .in_ready(w1_in_ready), .in_data(w1_in_data), .out_valid(w1_out_valid),
        .out_ready(w1_out_ready), .out_max(w1_out_max), .out_idx(w1_out_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned strict greater-than, earliest index on ties.
    function automatic logic [6:0] model(input win_t s);
        logic [3:0] m;
        logic [2:0] ix;
        m  = s[0];
        ix = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (s[i] > m) begin
                m  = s[i];
                ix = 3'(i);
            end
        end
        return {ix, m};
    endfunction

    // Called at a negedge; returns at the negedge after the sample was accepted.
    task automatic push_sample(input logic [3:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_window(input win_t s, input bit gapped);
        exp_q.push_back(model(s));
        for (int i = 0; i < 8; i++) begin
            push_sample(s[i]);
            if (gapped && i < 7) @(negedge clk);
        end
    endtask

    task automatic expect_result(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, " unexpected result"}, 32'd1, 32'd0);
        end else begin
            last_exp = exp_q.pop_front();
            check({tag, " out_max"}, 32'(out_max), 32'(last_exp[3:0]));
            check({tag, " out_idx"}, 32'(out_idx), 32'(last_exp[6:4]));
        end
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        win_t s;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        w1_in_valid = 1'b0; w1_in_data = '0; w1_out_ready = 1'b1;
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_max", 32'(out_max), 32'd0);
        check("reset out_idx", 32'(out_idx), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back window; result visible right after the last accept.
        s = '{4'd3, 4'd7, 4'd2, 4'd7, 4'd1, 4'd9, 4'd0, 4'd4};
        send_window(s, 1'b0);
        check("s1 latency", 32'(out_valid), 32'd1);
        check("s1 in_ready low", 32'(in_ready), 32'd0);
        expect_result("s1");
        check("s1 in_ready back", 32'(in_ready), 32'd1);

        s = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        send_window(s, 1'b0);
        expect_result("s2 ties");
        s = '{4'b0111, 4'b1000, 4'b1011, 4'b1010, 4'd0, 4'd0, 4'd0, 4'd0};
        send_window(s, 1'b0);
        expect_result("s2 lowpair");

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        s = '{4'd1, 4'd12, 4'd3, 4'd14, 4'd14, 4'd2, 4'd0, 4'd6};
        send_window(s, 1'b0);
        expect_result("s3");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s3 hold valid", 32'(out_valid), 32'd1);
            check("s3 hold max", 32'(out_max), 32'(last_exp[3:0]));
            check("s3 hold idx", 32'(out_idx), 32'(last_exp[6:4]));
            check("s3 hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        s = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        send_window(s, 1'b0);
        expect_result("s3 fresh");

        s = '{4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        send_window(s, 1'b1);
        expect_result("s4 gapped");

        // Clear after 3 samples, with a sample offered in the clear cycle.
        push_sample(4'd9);
        push_sample(4'd9);
        push_sample(4'd9);
        clear = 1'b1; in_valid = 1'b1; in_data = 4'd15;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check("s5 after clear", 32'(out_valid), 32'd0);
        s = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        send_window(s, 1'b0);
        expect_result("s5");

        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 8; i++) s[i] = 4'($urandom_range(0, 15));
            send_window(s, 1'b0);
            expect_result("rand");
        end

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0;
        s = '{4'd4, 4'd13, 4'd2, 4'd8, 4'd8, 4'd1, 4'd0, 4'd3};
        send_window(s, 1'b0);
        expect_result("s6 pre");
        #2 rst_n = 1'b0;
        #1;
        check("s6 rst out_valid", 32'(out_valid), 32'd0);
        check("s6 rst out_max", 32'(out_max), 32'd0);
        check("s6 rst out_idx", 32'(out_idx), 32'd0);
        check("s6 rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        s = '{4'd3, 4'd7, 4'd2, 4'd7, 4'd1, 4'd9, 4'd0, 4'd4};
        send_window(s, 1'b0);
        check("s6 latency", 32'(out_valid), 32'd1);
        expect_result("s6 post");

        // WINDOW=1 instance: each sample is its own result.
        w1_in_valid = 1'b1; w1_in_data = 4'd6;
        @(negedge clk);
        check("w1 first valid", 32'(w1_out_valid), 32'd1);
        check("w1 first max", 32'(w1_out_max), 32'd6);
        check("w1 first idx", 32'(w1_out_idx), 32'd0);
        check("w1 first in_ready", 32'(w1_in_ready), 32'd0);
        w1_in_data = 4'd2;
        @(negedge clk);
        check("w1 gap valid", 32'(w1_out_valid), 32'd0);
        @(negedge clk);
        w1_in_valid = 1'b0;
        check("w1 second valid", 32'(w1_out_valid), 32'd1);
        check("w1 second max", 32'(w1_out_max), 32'd2);
        check("w1 second idx", 32'(w1_out_idx), 32'd0);
        @(negedge clk);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
